mat_slot_sched: RTL and testbench

- Allocation and lookup scheduler for matrix storage, fed by the parameter configuration block's max_mat_num/config_done outputs.
- Storage is divided into 25 dimension classes (m,n each 1..5); each class owns 5 physical slots (slot = class*5 + idx, 0..124).
- Serves one request at a time from the input, display and compute front-ends: alloc (write new matrix, ring-overwrite oldest when full), query (k-th stored matrix, oldest first) and count.
- Flushes all bookkeeping when a new configuration is accepted.

---
 rtl/mat_pkg.sv | 52 +++++
 rtl/mat_ring_idx.sv | 33 +++
 rtl/mat_slot_sched.sv | 183 ++++++++++++++++++
 tb/tb_mat_slot_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared constants, encodings and dimension helpers for the matrix slot scheduler.
package mat_pkg;

   localparam int unsigned DIM_MAX       = 5;
   localparam int unsigned SLOTS_PER_DIM = 5;
   localparam int unsigned NUM_CLASS     = DIM_MAX * DIM_MAX;
   localparam int unsigned SLOT_W        = 7;
   localparam logic [2:0]  LIM_RST_DEF   = 3'd2;

   typedef enum logic [1:0] {
      OP_ALLOC = 2'b00,
      OP_QUERY = 2'b01,
      OP_COUNT = 2'b10,
      OP_ILL   = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ERR_OK   = 3'b000,
      ERR_OP   = 3'b010,
      ERR_CFG  = 3'b011,
      ERR_FULL = 3'b100,
      ERR_DIM  = 3'b101,
      ERR_IDX  = 3'b110
   } err_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_FLUSH
   } state_e;

   function automatic logic dim_ok(input logic [2:0] d);
      return (d != 3'd0) && (d <= 3'(DIM_MAX));
   endfunction

   // Only meaningful when both dimensions pass dim_ok.
   function automatic logic [4:0] class_of(input logic [2:0] m, input logic [2:0] n);
      return ({2'b00, m} - 5'd1) * 5'(DIM_MAX) + ({2'b00, n} - 5'd1);
   endfunction

   function automatic logic [2:0] clamp_lim(input logic [3:0] v);
      logic [2:0] r;
      if (v == 4'd0)
         r = 3'd1;
      else if (v > 4'(SLOTS_PER_DIM))
         r = 3'(SLOTS_PER_DIM);
      else
         r = v[2:0];
      return r;
   endfunction

endpackage

// File: rtl/mat_ring_idx.sv
// Ring-buffer index arithmetic for one dimension class: k-th oldest slot,
// next write pointer and absent-index detection. Purely combinational.
module mat_ring_idx (
   input  logic [2:0] count,
   input  logic [2:0] wp,
   input  logic [2:0] lim,
   input  logic [2:0] k,
   output logic [2:0] idx,
   output logic [2:0] wp_nxt,
   output logic       absent
);

   logic [2:0] oldest;
   logic [3:0] lim4;
   logic [3:0] sum;
   logic [3:0] sum_wrap;
   logic [3:0] wp_sum;
   logic [3:0] wp_wrap;

   always_comb begin
      lim4   = {1'b0, lim};
      oldest = (count < lim) ? 3'd0 : wp;
      // Operands stay below 9, so one conditional subtract replaces a modulo.
      sum      = {1'b0, oldest} + {1'b0, k} - 4'd1;
      sum_wrap = sum - lim4;
      idx      = (sum >= lim4) ? sum_wrap[2:0] : sum[2:0];
      wp_sum   = {1'b0, wp} + 4'd1;
      wp_wrap  = wp_sum - lim4;
      wp_nxt   = (wp_sum >= lim4) ? wp_wrap[2:0] : wp_sum[2:0];
      absent   = (k == 3'd0) || (k > count);
   end

endmodule

// File: rtl/mat_slot_sched.sv
// Per-dimension-class slot allocator: alloc with ring overwrite, k-th oldest
// lookup and count, one request at a time; bookkeeping flushed on new config.
module mat_slot_sched
   import mat_pkg::*;
#(
   parameter logic [2:0] LIM_RST = LIM_RST_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] max_mat_num,
   input  logic       cfg_done,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   input  logic [2:0] req_m,
   input  logic [2:0] req_n,
   input  logic [2:0] req_k,
   output logic       rsp_valid,
   output logic [6:0] rsp_slot,
   output logic [2:0] rsp_count,
   output logic       rsp_evict,
   output logic [2:0] rsp_err
);

   state_e state_q, state_d;
   logic [2:0] lim_q, lim_d;
   logic       pend_q, pend_d;
   op_e        op_q, op_d;
   logic [2:0] m_q, m_d, n_q, n_d, k_q, k_d;
   logic [NUM_CLASS-1:0][2:0] cnt_q, cnt_d;
   logic [NUM_CLASS-1:0][2:0] wp_q, wp_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [6:0] rsp_slot_q, rsp_slot_d;
   logic [2:0] rsp_count_q, rsp_count_d;
   logic       rsp_evict_q, rsp_evict_d;
   logic [2:0] rsp_err_q, rsp_err_d;

   logic       dims_ok;
   logic [4:0] cls;
   logic [2:0] cur_cnt, cur_wp;
   logic [6:0] slot_base;
   logic [2:0] ring_idx, ring_wp_nxt;
   logic       ring_absent;

   always_comb begin
      dims_ok   = dim_ok(m_q) && dim_ok(n_q);
      cls       = dims_ok ? class_of(m_q, n_q) : 5'd0;
      cur_cnt   = cnt_q[cls];
      cur_wp    = wp_q[cls];
      slot_base = {2'b00, cls} * 7'(SLOTS_PER_DIM);
   end

   mat_ring_idx u_ring (
      .count  (cur_cnt),
      .wp     (cur_wp),
      .lim    (lim_q),
      .k      (k_q),
      .idx    (ring_idx),
      .wp_nxt (ring_wp_nxt),
      .absent (ring_absent)
   );

   always_comb begin
      state_d     = state_q;
      lim_d       = lim_q;
      pend_d      = pend_q;
      op_d        = op_q;
      m_d         = m_q;
      n_d         = n_q;
      k_d         = k_q;
      cnt_d       = cnt_q;
      wp_d        = wp_q;
      rsp_valid_d = 1'b0;
      rsp_slot_d  = rsp_slot_q;
      rsp_count_d = rsp_count_q;
      rsp_evict_d = rsp_evict_q;
      rsp_err_d   = rsp_err_q;
      req_ready   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            req_ready = !(cfg_done || pend_q);
            if (cfg_done || pend_q) begin
               state_d = ST_FLUSH;
            end else if (req_valid) begin
               op_d    = op_e'(req_op);
               m_d     = req_m;
               n_d     = req_n;
               k_d     = req_k;
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            state_d     = ST_IDLE;
            pend_d      = pend_q || cfg_done;
            rsp_valid_d = 1'b1;
            rsp_slot_d  = '0;
            rsp_count_d = '0;
            rsp_evict_d = 1'b0;
            rsp_err_d   = ERR_OK;
            if (op_q == OP_ILL) begin
               rsp_err_d = ERR_OP;
            end else if (!dims_ok) begin
               rsp_err_d = ERR_DIM;
            end else begin
               rsp_count_d = cur_cnt;
               unique case (op_q)
                  OP_ALLOC: begin
                     rsp_slot_d = slot_base + {4'b0000, cur_wp};
                     wp_d[cls]  = ring_wp_nxt;
                     if (cur_cnt < lim_q) begin
                        cnt_d[cls]  = cur_cnt + 3'd1;
                        rsp_count_d = cur_cnt + 3'd1;
                     end else begin
                        rsp_evict_d = 1'b1;
                     end
                  end
                  OP_QUERY: begin
                     if (ring_absent)
                        rsp_err_d = ERR_IDX;
                     else
                        rsp_slot_d = slot_base + {4'b0000, ring_idx};
                  end
                  default: ;
               endcase
            end
         end

         ST_FLUSH: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            wp_d    = '0;
            lim_d   = clamp_lim(max_mat_num);
            // A config landing during the flush still needs its own flush.
            pend_d  = cfg_done;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         lim_q       <= LIM_RST;
         pend_q      <= 1'b0;
         op_q        <= OP_ALLOC;
         m_q         <= '0;
         n_q         <= '0;
         k_q         <= '0;
         cnt_q       <= '0;
         wp_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_slot_q  <= '0;
         rsp_count_q <= '0;
         rsp_evict_q <= 1'b0;
         rsp_err_q   <= '0;
      end else begin
         state_q     <= state_d;
         lim_q       <= lim_d;
         pend_q      <= pend_d;
         op_q        <= op_d;
         m_q         <= m_d;
         n_q         <= n_d;
         k_q         <= k_d;
         cnt_q       <= cnt_d;
         wp_q        <= wp_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_slot_q  <= rsp_slot_d;
         rsp_count_q <= rsp_count_d;
         rsp_evict_q <= rsp_evict_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_slot  = rsp_slot_q;
   assign rsp_count = rsp_count_q;
   assign rsp_evict = rsp_evict_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mat_slot_sched.sv
// Scoreboard bench for mat_slot_sched: per-class FIFO reference model, directed
// scenarios followed by randomized requests and config pulses.
module tb_mat_slot_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] max_mat_num;
   logic       cfg_done;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [2:0] req_m, req_n, req_k;
   logic       rsp_valid;
   logic [6:0] rsp_slot;
   logic [2:0] rsp_count;
   logic       rsp_evict;
   logic [2:0] rsp_err;

   always #5 clk = ~clk;

   mat_slot_sched dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .max_mat_num (max_mat_num),
      .cfg_done    (cfg_done),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_m       (req_m),
      .req_n       (req_n),
      .req_k       (req_k),
      .rsp_valid   (rsp_valid),
      .rsp_slot    (rsp_slot),
      .rsp_count   (rsp_count),
      .rsp_evict   (rsp_evict),
      .rsp_err     (rsp_err)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      int slot;
      int count;
      int evict;
      int err;
      int due;
   } exp_t;

   exp_t expq[$];

   // Reference model: each class is an ordered list (oldest first) of slot indices.
   int lim_m;
   int sz[25];
   int sl[25][5];

   logic last_acc;
   logic last_rdy;

   function automatic void chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void fail_now(string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: bound expired at cycle %0d", name, cyc);
   endfunction

   function automatic void model_flush(int mx);
      lim_m = (mx == 0) ? 1 : (mx > 5) ? 5 : mx;
      for (int c = 0; c < 25; c++) sz[c] = 0;
   endfunction

   function automatic exp_t model_exec(int op, int m, int n, int k);
      exp_t e;
      int   c, idx;
      e.slot = 0; e.count = 0; e.evict = 0; e.err = 0; e.due = 0;
      if (op == 3) begin
         e.err = 2;
      end else if (m < 1 || m > 5 || n < 1 || n > 5) begin
         e.err = 5;
      end else begin
         c = (m - 1) * 5 + (n - 1);
         if (op == 0) begin
            if (sz[c] < lim_m) begin
               idx = sz[c];
               sl[c][sz[c]] = idx;
               sz[c]++;
            end else begin
               idx = sl[c][0];
               for (int i = 0; i < 4; i++) sl[c][i] = sl[c][i+1];
               sl[c][lim_m-1] = idx;
               e.evict = 1;
            end
            e.slot = c * 5 + idx;
         end else if (op == 1) begin
            if (k < 1 || k > sz[c]) e.err = 6;
            else                    e.slot = c * 5 + sl[c][k-1];
         end
         e.count = sz[c];
      end
      return e;
   endfunction

   // One clock: observe handshake/config at the negedge, then move just past the posedge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      last_rdy = req_ready;
      last_acc = req_valid && req_ready && rst_n;
      if (last_acc) begin
         e = model_exec(int'(req_op), int'(req_m), int'(req_n), int'(req_k));
         e.due = cyc + 2;
         expq.push_back(e);
      end
      if (cfg_done && rst_n) model_flush(int'(max_mat_num));
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int op, input int m, input int n, input int k);
      req_op    = 2'(op);
      req_m     = 3'(m);
      req_n     = 3'(n);
      req_k     = 3'(k);
      req_valid = 1'b1;
      last_acc  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (last_acc) break;
      end
      if (!last_acc) fail_now("accept_timeout");
      req_valid = 1'b0;
   endtask

   task automatic pulse_cfg(input int mx);
      max_mat_num = 4'(mx);
      cfg_done    = 1'b1;
      step();
      cfg_done    = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && rsp_valid) begin
         if (expq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid, expected no response (cycle %0d)", cyc);
         end else begin
            e = expq.pop_front();
            chk("latency", cyc, e.due);
            chk("rsp_slot", int'(rsp_slot), e.slot);
            chk("rsp_count", int'(rsp_count), e.count);
            chk("rsp_evict", int'(rsp_evict), e.evict);
            chk("rsp_err", int'(rsp_err), e.err);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      max_mat_num = 4'd0;
      cfg_done    = 1'b0;
      req_valid   = 1'b0;
      req_op      = 2'd0;
      req_m       = 3'd0;
      req_n       = 3'd0;
      req_k       = 3'd0;
      lim_m       = 2;
      for (int c = 0; c < 25; c++) sz[c] = 0;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", int'(req_ready), 1);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_rsp_slot", int'(rsp_slot), 0);
      chk("rst_rsp_count", int'(rsp_count), 0);
      chk("rst_rsp_evict", int'(rsp_evict), 0);
      chk("rst_rsp_err", int'(rsp_err), 0);
      @(posedge clk);
      #1;

      // Default limit 2: ring overwrite in class 2x3, then lookups.
      repeat (3) send(0, 2, 3, 0);
      for (int k = 1; k <= 3; k++) send(1, 2, 3, k);
      send(2, 2, 3, 0);

      // New limit clamps 7 -> 5.
      idle(3);
      pulse_cfg(7);
      idle(3);
      send(2, 2, 3, 0);
      repeat (6) send(0, 5, 5, 0);
      for (int k = 0; k <= 6; k++) send(1, 5, 5, k);

      // Config and request in the same idle cycle: config wins.
      idle(4);
      max_mat_num = 4'd3;
      cfg_done    = 1'b1;
      req_op      = 2'd0; req_m = 3'd1; req_n = 3'd1; req_k = 3'd0;
      req_valid   = 1'b1;
      step();
      chk("ready_on_cfg", int'(last_rdy), 0);
      chk("accept_on_cfg", int'(last_acc), 0);
      cfg_done = 1'b0;
      send(0, 1, 1, 0);

      // Config arriving while a request executes.
      send(0, 1, 1, 0);
      send(2, 1, 1, 0);
      cfg_done = 1'b1;
      step();
      cfg_done = 1'b0;
      send(2, 1, 1, 0);

      // Error cases and the limit-of-one corner.
      send(2, 0, 3, 0);
      send(0, 3, 6, 0);
      send(3, 2, 2, 0);
      send(1, 4, 4, 0);
      idle(3);
      pulse_cfg(0);
      idle(3);
      send(0, 4, 2, 0);
      send(0, 4, 2, 0);
      send(1, 4, 2, 1);
      send(1, 4, 2, 2);

      // Randomized traffic over a few classes so rings fill and wrap.
      for (int i = 0; i < 800; i++) begin
         int r;
         r         = int'($urandom % 16);
         req_valid = ($urandom % 10) < 7;
         req_op    = (r < 6) ? 2'd0 : (r < 11) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
         req_m     = (($urandom % 12) == 0) ? 3'($urandom % 8) : 3'($urandom_range(1, 2));
         req_n     = (($urandom % 12) == 0) ? 3'($urandom % 8) : 3'($urandom_range(4, 5));
         req_k     = 3'($urandom % 7);
         cfg_done  = (($urandom % 40) == 0);
         if (cfg_done) max_mat_num = 4'($urandom % 16);
         step();
      end
      req_valid = 1'b0;
      cfg_done  = 1'b0;

      for (int i = 0; i < 20 && expq.size() != 0; i++) step();
      if (expq.size() != 0) fail_now("drain_timeout");
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
